// File: rtl/bus_pkg.sv
// Shared types for the bus traffic master: op encoding, FSM states, default bus widths
// and the saturating counter step used by the error/timeout counters.
package bus_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  typedef enum logic [1:0] {
    OP_NOP        = 2'b00,
    OP_READ       = 2'b01,
    OP_WRITE      = 2'b10,
    OP_READ_CHECK = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ARB,
    ST_XFER,
    ST_ADV
  } state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bus_traffic_master_if.sv
// Shared request/grant/ready bus; address, r_w and data are tri-state nets
// so several masters and a slave can sit on them at once.
interface bus_traffic_master_if
  import bus_pkg::*;
#(
  parameter int AW = BUS_AW,
  parameter int DW = BUS_DW
);

  logic          request;
  logic          grant;
  logic          ready;
  wire  [AW-1:0] address;
  wire           r_w;
  wire  [DW-1:0] data;

  modport master (
    output request,
    input  grant,
    input  ready,
    output address,
    output r_w,
    inout  data
  );

  modport slave (
    input  request,
    output grant,
    output ready,
    input  address,
    input  r_w,
    inout  data
  );

endinterface

// File: rtl/op_table_ram.sv
// Operation table storage: one synchronous write port, combinational read.
// Deliberately not reset so a program survives a reset of the master.
module op_table_ram #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  localparam int IW   = $clog2(DEPTH),
  localparam int EW   = 3 + AW + DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [EW-1:0] rdata
);

  logic [EW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bus_traffic_master.sv
// Programmable bus master: walks an op table (NOP/READ/WRITE/READ_CHECK) once or in a
// loop, checks read data and counts mismatches and per-op timeouts.
module bus_traffic_master
  import bus_pkg::*;
#(
  parameter int AW      = BUS_AW,
  parameter int DW      = BUS_DW,
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 255,
  localparam int IW     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   prog_we,
  input  logic [IW-1:0]          prog_idx,
  input  logic [1:0]             prog_op,
  input  logic [AW-1:0]          prog_addr,
  input  logic [DW-1:0]          prog_data,
  input  logic                   prog_last,
  input  logic                   start,
  input  logic                   loop_en,
  input  logic                   stop,
  bus_traffic_master_if.master   bus,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_valid,
  output logic [DW-1:0]          rd_data,
  output logic [15:0]            err_cnt,
  output logic [15:0]            to_cnt
);

  localparam int EW = 3 + AW + DW;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_e        state;
  logic [IW-1:0] ptr;
  logic [TW-1:0] tcnt;
  logic          req_q;
  logic          loop_q;
  logic          stop_q;
  logic          stop_any;
  logic          xfer_drive;
  op_e           cur_op;
  logic          cur_last;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data;
  logic [EW-1:0] rd_entry;

  op_table_ram #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_table (
    .clk   (clk),
    .we    (prog_we && !busy),
    .waddr (prog_idx),
    .wdata ({prog_op, prog_last, prog_addr, prog_data}),
    .raddr (ptr),
    .rdata (rd_entry)
  );

  assign stop_any = stop_q | stop;

  // Pins are released purely from state and grant, so an async reset frees the bus at once.
  assign xfer_drive  = (state == ST_XFER) && bus.grant;
  assign bus.request = req_q;
  assign bus.address = xfer_drive ? cur_addr : {AW{1'bz}};
  assign bus.r_w     = xfer_drive ? (cur_op == OP_WRITE) : 1'bz;
  assign bus.data    = (xfer_drive && cur_op == OP_WRITE) ? cur_data : {DW{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      tcnt     <= '0;
      req_q    <= 1'b0;
      loop_q   <= 1'b0;
      stop_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      err_cnt  <= '0;
      to_cnt   <= '0;
      cur_op   <= OP_NOP;
      cur_last <= 1'b0;
      cur_addr <= '0;
      cur_data <= '0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      if (busy && stop) stop_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_FETCH;
            ptr     <= '0;
            busy    <= 1'b1;
            loop_q  <= loop_en;
            stop_q  <= 1'b0;
            err_cnt <= '0;
            to_cnt  <= '0;
          end
        end
        ST_FETCH: begin
          cur_op   <= op_e'(rd_entry[EW-1 -: 2]);
          cur_last <= rd_entry[AW+DW];
          cur_addr <= rd_entry[AW+DW-1 -: AW];
          cur_data <= rd_entry[DW-1:0];
          tcnt     <= '0;
          if (op_e'(rd_entry[EW-1 -: 2]) == OP_NOP) begin
            state <= ST_ADV;
          end else begin
            state <= ST_ARB;
            req_q <= 1'b1;
          end
        end
        ST_ARB: begin
          tcnt <= tcnt + TW'(1);
          if (bus.grant) begin
            state <= ST_XFER;
          end else if (tcnt >= T_LAST) begin
            req_q  <= 1'b0;
            to_cnt <= sat_inc(to_cnt);
            state  <= ST_ADV;
          end
        end
        ST_XFER: begin
          tcnt <= tcnt + TW'(1);
          if (bus.grant && bus.ready) begin
            req_q <= 1'b0;
            state <= ST_ADV;
            if (cur_op != OP_WRITE) begin
              rd_data  <= bus.data;
              rd_valid <= 1'b1;
              if (cur_op == OP_READ_CHECK && bus.data != cur_data) err_cnt <= sat_inc(err_cnt);
            end
          end else if (tcnt >= T_LAST) begin
            req_q  <= 1'b0;
            to_cnt <= sat_inc(to_cnt);
            state  <= ST_ADV;
          end else if (!bus.grant) begin
            state <= ST_ARB;
          end
        end
        ST_ADV: begin
          if (cur_last || stop_any) begin
            if (loop_q && !stop_any) begin
              ptr   <= '0;
              state <= ST_FETCH;
            end else begin
              state  <= ST_IDLE;
              done   <= 1'b1;
              busy   <= 1'b0;
              stop_q <= 1'b0;
            end
          end else begin
            ptr   <= ptr + IW'(1);
            state <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_traffic_master.sv
// Directed bench for bus_traffic_master with a simple arbiter, a slave memory model
// and a second master that only competes for grant.
module tb_bus_traffic_master;
  import bus_pkg::*;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int DEPTH   = 32;
  localparam int TIMEOUT = 8;
  localparam int IW      = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          prog_we = 1'b0;
  logic [IW-1:0] prog_idx = '0;
  logic [1:0]    prog_op = 2'b00;
  logic [AW-1:0] prog_addr = '0;
  logic [DW-1:0] prog_data = '0;
  logic          prog_last = 1'b0;
  logic          start = 1'b0;
  logic          loop_en = 1'b0;
  logic          stop = 1'b0;
  logic          busy, done, rd_valid;
  logic [DW-1:0] rd_data;
  logic [15:0]   err_cnt, to_cnt;

  logic          gnt_en = 1'b1;
  logic          rdy_en = 1'b1;
  logic          req2 = 1'b0;
  logic          grant2;
  logic [DW-1:0] smem [64];
  logic          poke_we = 1'b0;
  logic [5:0]    poke_a = '0;
  logic [DW-1:0] poke_d = '0;

  int total = 0;
  int passed = 0;

  int req_rises, low_run, max_low_run, g2_cnt, hi_run, first_hi, addr_leak, rdv_cnt, stop_at_rise;
  bit prev_req, stop_sent, tmo_mode;

  bus_traffic_master_if #(.AW(AW), .DW(DW)) bus ();

  bus_traffic_master #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prog_we   (prog_we),
    .prog_idx  (prog_idx),
    .prog_op   (prog_op),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_last (prog_last),
    .start     (start),
    .loop_en   (loop_en),
    .stop      (stop),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .err_cnt   (err_cnt),
    .to_cnt    (to_cnt)
  );

  always #5 clk = ~clk;

  // Arbiter favours the DUT; the second master only wins when the DUT is not requesting.
  assign bus.grant = bus.request & gnt_en;
  assign bus.ready = bus.grant & rdy_en;
  assign grant2    = req2 & ~bus.request;
  assign bus.data  = (bus.grant && bus.r_w == 1'b0) ? smem[bus.address[5:0]] : {DW{1'bz}};

  always @(posedge clk) begin
    if (poke_we) smem[poke_a] <= poke_d;
    if (bus.grant && bus.ready && bus.r_w == 1'b1) smem[bus.address[5:0]] <= bus.data;
  end

  task automatic clear_stats();
    req_rises = 0; low_run = 0; max_low_run = 0; g2_cnt = 0; hi_run = 0; first_hi = 0;
    addr_leak = 0; rdv_cnt = 0; stop_at_rise = 0; prev_req = 1'b0; stop_sent = 1'b0;
    tmo_mode = 1'b0; gnt_en = 1'b1; rdy_en = 1'b1; req2 = 1'b0; stop = 1'b0;
  endtask

  task automatic sample_stats();
    stop = 1'b0;
    if (bus.request && !prev_req) req_rises++;
    if (bus.request) hi_run++;
    else begin
      if (prev_req && first_hi == 0) first_hi = hi_run;
      hi_run = 0;
    end
    if (!bus.request && busy && req_rises > 0) begin
      low_run++;
      if (low_run > max_low_run) max_low_run = low_run;
    end else low_run = 0;
    if (grant2 && busy && req_rises > 0) g2_cnt++;
    if (!bus.grant && !(bus.address === '0 || bus.address === 'z)) addr_leak++;
    if (rd_valid) rdv_cnt++;
    if (tmo_mode && prev_req && !bus.request) gnt_en = 1'b1;
    if (stop_at_rise > 0 && req_rises == stop_at_rise && !stop_sent) begin
      stop = 1'b1;
      stop_sent = 1'b1;
    end
    prev_req = bus.request;
  endtask

  task automatic applyStimulus_prog(input int idx, input op_e op, input logic [AW-1:0] a,
                                    input logic [DW-1:0] d, input logic last);
    @(negedge clk);
    prog_we = 1'b1; prog_idx = IW'(idx); prog_op = op; prog_addr = a; prog_data = d; prog_last = last;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic poke(input logic [5:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    poke_we = 1'b1; poke_a = a; poke_d = d;
    @(negedge clk);
    poke_we = 1'b0;
  endtask

  task automatic pulse_start(input logic lp);
    @(negedge clk);
    start = 1'b1; loop_en = lp;
    @(negedge clk);
    start = 1'b0; loop_en = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cycles++;
      sample_stats();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (request_v() !== 1'b0) $display("[TB] FAIL rst_request: got %b want 0", bus.request); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0 || rd_valid !== 1'b0) $display("[TB] FAIL rst_pulses: got done=%b rd_valid=%b want 0/0", done, rd_valid); else passed++;
    total++; if (rd_data !== '0) $display("[TB] FAIL rst_rd_data: got %h want 0", rd_data); else passed++;
    total++; if (err_cnt !== 16'd0 || to_cnt !== 16'd0) $display("[TB] FAIL rst_counters: got %h/%h want 0/0", err_cnt, to_cnt); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic request_v();
    return bus.request;
  endfunction

  task automatic test_write_readback();
    bit ok; int cyc;
    clear_stats();
    applyStimulus_prog(0, OP_WRITE, 32'd15, 32'hA7, 1'b0);
    applyStimulus_prog(1, OP_READ_CHECK, 32'd15, 32'hA7, 1'b1);
    pulse_start(1'b0);
    wait_done(40, ok, cyc);
    total++; if (!ok) $display("[TB] FAIL wr_rd_done: got timeout want done"); else passed++;
    total++; if (cyc !== 8) $display("[TB] FAIL wr_rd_latency: got %0d want 8", cyc); else passed++;
    total++; if (rd_data !== 32'hA7) $display("[TB] FAIL wr_rd_data: got %h want 000000a7", rd_data); else passed++;
    total++; if (smem[15] !== 32'hA7) $display("[TB] FAIL wr_rd_slave_mem: got %h want 000000a7", smem[15]); else passed++;
    total++; if (err_cnt !== 16'd0 || to_cnt !== 16'd0) $display("[TB] FAIL wr_rd_counters: got %0d/%0d want 0/0", err_cnt, to_cnt); else passed++;
    total++; if (rdv_cnt !== 1) $display("[TB] FAIL wr_rd_rd_valid: got %0d want 1", rdv_cnt); else passed++;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL wr_rd_idle: got busy=%b done=%b want 0/0", busy, done); else passed++;
  endtask

  task automatic test_read_check_mismatch();
    bit ok; int cyc;
    clear_stats();
    poke(6'd48, 32'h3322FA42);
    applyStimulus_prog(0, OP_READ_CHECK, 32'd48, 32'h3322FA43, 1'b1);
    pulse_start(1'b0);
    wait_done(40, ok, cyc);
    total++; if (!ok) $display("[TB] FAIL chk_done: got timeout want done"); else passed++;
    total++; if (err_cnt !== 16'd1) $display("[TB] FAIL chk_err_cnt: got %0d want 1", err_cnt); else passed++;
    total++; if (rd_data !== 32'h3322FA42) $display("[TB] FAIL chk_rd_data: got %h want 3322fa42", rd_data); else passed++;
    total++; if (rdv_cnt !== 1) $display("[TB] FAIL chk_rd_valid: got %0d want 1", rdv_cnt); else passed++;
  endtask

  task automatic test_nop_gap();
    bit ok; int cyc;
    clear_stats();
    applyStimulus_prog(0, OP_WRITE, 32'h10, 32'h1111, 1'b0);
    applyStimulus_prog(1, OP_NOP, 32'h0, 32'h0, 1'b0);
    applyStimulus_prog(2, OP_WRITE, 32'h11, 32'h2222, 1'b1);
    req2 = 1'b1;
    pulse_start(1'b0);
    wait_done(60, ok, cyc);
    req2 = 1'b0;
    total++; if (!ok) $display("[TB] FAIL nop_done: got timeout want done"); else passed++;
    total++; if (max_low_run !== 4) $display("[TB] FAIL nop_gap_len: got %0d want 4", max_low_run); else passed++;
    total++; if (g2_cnt == 0) $display("[TB] FAIL nop_second_master: got %0d grants want >0", g2_cnt); else passed++;
    total++; if (req_rises !== 2) $display("[TB] FAIL nop_ops: got %0d want 2", req_rises); else passed++;
    total++; if (smem[16] !== 32'h1111 || smem[17] !== 32'h2222) $display("[TB] FAIL nop_writes: got %h/%h want 1111/2222", smem[16], smem[17]); else passed++;
  endtask

  task automatic test_timeout();
    bit ok; int cyc;
    clear_stats();
    applyStimulus_prog(0, OP_READ, 32'h21, 32'h0, 1'b0);
    applyStimulus_prog(1, OP_WRITE, 32'h22, 32'h3333, 1'b1);
    gnt_en = 1'b0;
    tmo_mode = 1'b1;
    pulse_start(1'b0);
    wait_done(80, ok, cyc);
    total++; if (!ok) $display("[TB] FAIL tmo_done: got timeout want done"); else passed++;
    total++; if (first_hi !== TIMEOUT) $display("[TB] FAIL tmo_req_cycles: got %0d want %0d", first_hi, TIMEOUT); else passed++;
    total++; if (to_cnt !== 16'd1) $display("[TB] FAIL tmo_to_cnt: got %0d want 1", to_cnt); else passed++;
    total++; if (req_rises !== 2) $display("[TB] FAIL tmo_next_op: got %0d want 2", req_rises); else passed++;
    total++; if (smem[34] !== 32'h3333) $display("[TB] FAIL tmo_next_write: got %h want 3333", smem[34]); else passed++;
    total++; if (addr_leak !== 0) $display("[TB] FAIL tmo_addr_z: got %0d driven cycles want 0", addr_leak); else passed++;
    total++; if (rdv_cnt !== 0) $display("[TB] FAIL tmo_rd_valid: got %0d want 0", rdv_cnt); else passed++;
  endtask

  task automatic test_loop_stop();
    bit ok; int cyc;
    clear_stats();
    applyStimulus_prog(0, OP_WRITE, 32'h01, 32'h1, 1'b0);
    applyStimulus_prog(1, OP_WRITE, 32'h02, 32'h2, 1'b0);
    applyStimulus_prog(2, OP_WRITE, 32'h03, 32'h3, 1'b1);
    stop_at_rise = 5;
    pulse_start(1'b1);
    wait_done(100, ok, cyc);
    total++; if (!ok) $display("[TB] FAIL loop_done: got timeout want done"); else passed++;
    total++; if (req_rises !== 5) $display("[TB] FAIL loop_ops: got %0d want 5", req_rises); else passed++;
    repeat (4) begin
      @(negedge clk);
      sample_stats();
    end
    total++; if (busy !== 1'b0 || req_rises !== 5) $display("[TB] FAIL loop_stays_idle: got busy=%b ops=%0d want 0/5", busy, req_rises); else passed++;
  endtask

  task automatic test_reset_mid_xfer();
    bit ok; int cyc;
    clear_stats();
    applyStimulus_prog(0, OP_WRITE, 32'h2C, 32'h5A5A, 1'b1);
    poke(6'h2C, 32'h0);
    rdy_en = 1'b0;
    pulse_start(1'b0);
    @(negedge clk);
    @(negedge clk);
    total++; if (bus.address !== 32'h2C || bus.r_w !== 1'b1 || bus.data !== 32'h5A5A)
      $display("[TB] FAIL rstx_driving: got a=%h rw=%b d=%h want 2c/1/5a5a", bus.address, bus.r_w, bus.data); else passed++;
    #1 rst_n = 1'b0;
    #1;
    total++; if (bus.request !== 1'b0) $display("[TB] FAIL rstx_request: got %b want 0", bus.request); else passed++;
    total++; if (!(bus.address === '0 || bus.address === 'z)) $display("[TB] FAIL rstx_address: got %h want z", bus.address); else passed++;
    total++; if (!(bus.data === '0 || bus.data === 'z)) $display("[TB] FAIL rstx_data: got %h want z", bus.data); else passed++;
    total++; if (!(bus.r_w === 1'b0 || bus.r_w === 1'bz)) $display("[TB] FAIL rstx_r_w: got %b want z", bus.r_w); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL rstx_busy: got %b want 0", busy); else passed++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    pulse_start(1'b0);
    wait_done(40, ok, cyc);
    total++; if (!ok) $display("[TB] FAIL rstx_restart_done: got timeout want done"); else passed++;
    total++; if (smem[44] !== 32'h5A5A) $display("[TB] FAIL rstx_table_kept: got %h want 5a5a", smem[44]); else passed++;
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_write_readback();
    test_read_check_mismatch();
    test_nop_gap();
    test_timeout();
    test_loop_stop();
    test_reset_mid_xfer();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bus_traffic_master.md
Name: bus_traffic_master

Overview:
- Parametrised, programmable bus master for exercising the shared request/grant/ready tri-state bus and its arbiter.
- Holds a runtime-loadable operation table: NOP, READ, WRITE, READ_CHECK.
- Executes the table once or in a loop, compares read data against expected values, and counts mismatches and timeouts.
- Sits beside real masters on the bus in system testbenches and FPGA bring-up builds.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- DEPTH, 32, operation-table entries (power of 2, ≥2). IW = $clog2(DEPTH).
- TIMEOUT, 255, max cycles spent in ARB+XFER for one op before abort (≥1).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- prog_we  in  1  write one table entry; ignored while busy=1.
- prog_idx  in  IW  entry index.
- prog_op  in  2  00 NOP, 01 READ, 10 WRITE, 11 READ_CHECK.
- prog_addr  in  AW  entry address.
- prog_data  in  DW  write data or expected read data.
- prog_last  in  1  marks final entry of the program.
- start  in  1  one-cycle pulse; begins at entry 0 when idle.
- loop_en  in  1  sampled at start; 1 = wrap to entry 0 after last.
- stop  in  1  finish current op, then go idle.
- request  out  1  bus request to arbiter.
- grant  in  1  arbiter grant.
- ready  in  1  slave completion strobe.
- address  out  AW  tri-state; driven only while grant=1.
- r_w  out  1  tri-state; 1 = write; driven only while grant=1.
- data  inout  DW  driven only while grant=1 and current op is WRITE; else Z.
- busy  out  1  program running.
- done  out  1  one-cycle pulse when program ends.
- rd_valid  out  1  one-cycle pulse; read completed.
- rd_data  out  DW  last captured read data.
- err_cnt  out  16  READ_CHECK mismatches; saturating.
- to_cnt  out  16  timed-out ops; saturating.

Behaviour:
- Reset (async assert, sync release): state=IDLE, ptr=0, request=0, busy=0, done=0, rd_valid=0, rd_data=0, err_cnt=0, to_cnt=0. Bus pins go Z immediately.
- Table RAM is not reset; its contents survive reset.
- States:
  - IDLE: on start go to FETCH with ptr=0, busy=1, latch loop_en. Both counters clear at start.
  - FETCH: decode entry[ptr], one cycle. NOP → ADV, with request held 0 that cycle (yields the bus). Otherwise → ARB, clear the timeout counter.
  - ARB: request=1. On grant=1 → XFER.
  - XFER: request=1 and bus driven. On ready=1 (sampled with grant=1):
    - reads latch data into rd_data and pulse rd_valid next cycle;
    - READ_CHECK with data≠prog_data increments err_cnt;
    - → ADV.
    - If grant drops before ready: → ARB and retry the same op. The timeout counter keeps running.
  - Timeout: in ARB or XFER, when the counter reaches TIMEOUT, drop request, increment to_cnt, → ADV.
  - ADV:
    - entry last=1 or stop seen: if loop latched and no stop, ptr=0 → FETCH; else → IDLE with done=1 for one cycle and busy=0.
    - otherwise ptr+1 → FETCH. ptr wraps at DEPTH-1 even without last.
- Op latency with grant and ready immediate: FETCH, ARB, XFER, ADV = 4 cycles. request is low in FETCH and ADV.
- stop is latched (sticky) until IDLE; the op in flight always completes or times out.
- start while busy is ignored. prog_we and start in the same idle cycle: the write lands first, and start takes effect.
- ready without grant, or outside XFER, is ignored.
- Saturating counters hold at 16'hFFFF.

Decomposition:
- Shared package bus_pkg: op encoding enum (NOP/READ/WRITE/READ_CHECK), state enum, bus width defaults.
- One natural sub-module, op_table_ram: DEPTH × (2+1+AW+DW), one synchronous write port, combinational read.

Test Plan:
- Program {WRITE 15←0xA7, READ_CHECK 15 exp 0xA7 last}, grant and ready tied high after request, slave model memory → done after 8 cycles, rd_data=0xA7, err_cnt=0, to_cnt=0.
- READ_CHECK 48 expecting 0x3322FA43, slave returns 0x3322FA42 → err_cnt=1, rd_valid pulses once.
- Entry NOP between two WRITEs → request low for ≥2 consecutive cycles; a second master is granted in that gap.
- Grant withheld, TIMEOUT=8 → request drops after 8 ARB cycles, to_cnt=1, next op starts, address stays Z throughout.
- loop_en=1 with a 3-entry program, stop asserted mid-op 2 of pass 2 → op 2 completes, done pulses, 5 ops total seen on bus.
- rst_n low during XFER → request, address, data and r_w go Z/0 the same cycle without a clock edge; after release, table contents are intact and a restart succeeds.
